multi_rule_filter: RTL and testbench

//  Parametrised successor of the single-rule header filter: it decides pass/drop for each parsed

---
 rtl/multi_rule_filter.sv | 192 +++++++++++++++++++
 tb/tb_multi_rule_filter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_rule_filter.sv
// Header filter with a programmable table of masked rules, first-match priority,
// default action, matched-rule index and saturating pass/drop counters.
module multi_rule_filter #(
    parameter int NUM_RULES      = 8,
    parameter int IP_ADDR_LEN    = 32,
    parameter int PORT_LEN       = 16,
    parameter int CNT_WIDTH      = 32,
    parameter int DEFAULT_ACTION = 0,
    localparam int IDX_W = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
    input  logic                   axi_aclk,
    input  logic                   axi_aresetn,
    input  logic                   hdr_rd,
    input  logic                   hdr_clear,
    input  logic [IP_ADDR_LEN-1:0] hdr_src_ip,
    input  logic [IP_ADDR_LEN-1:0] hdr_dst_ip,
    input  logic [PORT_LEN-1:0]    hdr_src_port,
    input  logic [PORT_LEN-1:0]    hdr_dst_port,
    input  logic                   rule_wr_en,
    input  logic [IDX_W-1:0]       rule_wr_idx,
    input  logic                   rule_wr_valid,
    input  logic                   rule_wr_action,
    input  logic [IP_ADDR_LEN-1:0] rule_wr_src_ip,
    input  logic [IP_ADDR_LEN-1:0] rule_wr_src_mask,
    input  logic [IP_ADDR_LEN-1:0] rule_wr_dst_ip,
    input  logic [IP_ADDR_LEN-1:0] rule_wr_dst_mask,
    input  logic [PORT_LEN-1:0]    rule_wr_dport,
    input  logic                   rule_wr_dport_any,
    input  logic                   stat_clear,
    output logic                   m_send,
    output logic                   m_send_rd,
    output logic                   m_rule_hit,
    output logic [IDX_W-1:0]       m_rule_idx,
    output logic [CNT_WIDTH-1:0]   pass_count,
    output logic [CNT_WIDTH-1:0]   drop_count
);

    localparam logic                 DEF_ACT = (DEFAULT_ACTION != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, MATCH, DECIDE, WAIT_CLEAR} state_t;
    state_t state_reg, state_next;

    logic [IP_ADDR_LEN-1:0] src_reg, dst_reg;
    logic [PORT_LEN-1:0]    dport_reg;
    logic [NUM_RULES-1:0]   match_comb, match_reg, action_vec, action_reg;
    logic                   hit_comb, act_comb, send_comb;
    logic [IDX_W-1:0]       idx_comb;
    logic                   send_reg, send_rd_reg, hit_reg;
    logic [IDX_W-1:0]       idx_reg;
    logic [CNT_WIDTH-1:0]   pass_reg, drop_reg;

    // The source port is not part of the match key.
    logic unused_sport;
    assign unused_sport = ^hdr_src_port;

    generate
        for (genvar gi = 0; gi < NUM_RULES; gi++) begin : g_rule
            logic                   valid_reg, action_r, any_reg;
            logic [IP_ADDR_LEN-1:0] src_r, smask_r, dst_r, dmask_r;
            logic [PORT_LEN-1:0]    dport_r;
            logic                   wr_sel;

            // Indices beyond the table never select an entry, so such writes vanish.
            assign wr_sel = rule_wr_en && (rule_wr_idx == IDX_W'(gi));

            always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
                if (!axi_aresetn) begin
                    valid_reg <= 1'b0;
                    action_r  <= 1'b0;
                    any_reg   <= 1'b0;
                    src_r     <= '0;
                    smask_r   <= '0;
                    dst_r     <= '0;
                    dmask_r   <= '0;
                    dport_r   <= '0;
                end else if (wr_sel) begin
                    valid_reg <= rule_wr_valid;
                    action_r  <= rule_wr_action;
                    any_reg   <= rule_wr_dport_any;
                    src_r     <= rule_wr_src_ip;
                    smask_r   <= rule_wr_src_mask;
                    dst_r     <= rule_wr_dst_ip;
                    dmask_r   <= rule_wr_dst_mask;
                    dport_r   <= rule_wr_dport;
                end
            end

            assign match_comb[gi] = valid_reg
                                  && (((src_reg ^ src_r) & smask_r) == '0)
                                  && (((dst_reg ^ dst_r) & dmask_r) == '0)
                                  && (any_reg || (dport_reg == dport_r));
            assign action_vec[gi] = action_r;
        end
    endgenerate

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit_comb = 1'b0;
        act_comb = 1'b0;
        idx_comb = '0;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (match_reg[i]) begin
                hit_comb = 1'b1;
                act_comb = action_reg[i];
                idx_comb = IDX_W'(i);
            end
        end
    end

    assign send_comb = hit_comb ? act_comb : DEF_ACT;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) state_reg <= IDLE;
        else              state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:       if (hdr_rd) state_next = MATCH;
            MATCH:      state_next = DECIDE;
            DECIDE:     state_next = WAIT_CLEAR;
            WAIT_CLEAR: if (hdr_clear) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            src_reg     <= '0;
            dst_reg     <= '0;
            dport_reg   <= '0;
            match_reg   <= '0;
            action_reg  <= '0;
            send_reg    <= 1'b0;
            send_rd_reg <= 1'b0;
            hit_reg     <= 1'b0;
            idx_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: if (hdr_rd) begin
                    src_reg   <= hdr_src_ip;
                    dst_reg   <= hdr_dst_ip;
                    dport_reg <= hdr_dst_port;
                end
                // Snapshot actions with the matches so a later write cannot alter this decision.
                MATCH: begin
                    match_reg  <= match_comb;
                    action_reg <= action_vec;
                end
                DECIDE: begin
                    send_reg    <= send_comb;
                    hit_reg     <= hit_comb;
                    idx_reg     <= idx_comb;
                    send_rd_reg <= 1'b1;
                end
                WAIT_CLEAR: if (hdr_clear) begin
                    send_reg    <= 1'b0;
                    hit_reg     <= 1'b0;
                    idx_reg     <= '0;
                    send_rd_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            pass_reg <= '0;
            drop_reg <= '0;
        end else if (stat_clear) begin
            pass_reg <= '0;
            drop_reg <= '0;
        end else if (state_reg == DECIDE) begin
            if (send_comb) begin
                if (!(&pass_reg)) pass_reg <= pass_reg + CNT_ONE;
            end else begin
                if (!(&drop_reg)) drop_reg <= drop_reg + CNT_ONE;
            end
        end
    end

    assign m_send     = send_reg;
    assign m_send_rd  = send_rd_reg;
    assign m_rule_hit = hit_reg;
    assign m_rule_idx = idx_reg;
    assign pass_count = pass_reg;
    assign drop_count = drop_reg;

endmodule

// File: tb/tb_multi_rule_filter.sv
// Bench for multi_rule_filter: six-entry table, 4-bit counters so saturation is reachable,
// directed table vectors, multi-cycle corner sequences and a randomized run against a rule model.
module tb_multi_rule_filter;

    localparam int NR = 6;
    localparam int IW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hdr_rd, hdr_clear, stat_clear;
    logic [31:0]   hdr_src_ip, hdr_dst_ip;
    logic [15:0]   hdr_src_port, hdr_dst_port;
    logic          rule_wr_en, rule_wr_valid, rule_wr_action, rule_wr_dport_any;
    logic [IW-1:0] rule_wr_idx;
    logic [31:0]   rule_wr_src_ip, rule_wr_src_mask, rule_wr_dst_ip, rule_wr_dst_mask;
    logic [15:0]   rule_wr_dport;
    logic          m_send, m_send_rd, m_rule_hit;
    logic [IW-1:0] m_rule_idx;
    logic [CW-1:0] pass_count, drop_count;

    multi_rule_filter #(
        .NUM_RULES(NR), .IP_ADDR_LEN(32), .PORT_LEN(16), .CNT_WIDTH(CW), .DEFAULT_ACTION(0)
    ) dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .hdr_rd(hdr_rd), .hdr_clear(hdr_clear),
        .hdr_src_ip(hdr_src_ip), .hdr_dst_ip(hdr_dst_ip),
        .hdr_src_port(hdr_src_port), .hdr_dst_port(hdr_dst_port),
        .rule_wr_en(rule_wr_en), .rule_wr_idx(rule_wr_idx),
        .rule_wr_valid(rule_wr_valid), .rule_wr_action(rule_wr_action),
        .rule_wr_src_ip(rule_wr_src_ip), .rule_wr_src_mask(rule_wr_src_mask),
        .rule_wr_dst_ip(rule_wr_dst_ip), .rule_wr_dst_mask(rule_wr_dst_mask),
        .rule_wr_dport(rule_wr_dport), .rule_wr_dport_any(rule_wr_dport_any),
        .stat_clear(stat_clear),
        .m_send(m_send), .m_send_rd(m_send_rd), .m_rule_hit(m_rule_hit),
        .m_rule_idx(m_rule_idx), .pass_count(pass_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int txn_no = 0;

    // Reference rule table and counters.
    bit          mv[NR], mact[NR], many[NR];
    logic [31:0] msrc[NR], msm[NR], mdst[NR], mdm[NR];
    logic [15:0] mdp[NR];
    int          exp_pass, exp_drop;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] dport;
        bit          send;
        bit          hit;
        logic [2:0]  idx;
    } vec_t;
    vec_t vecs[6];

    logic [31:0] ip_pool[5]   = '{32'hAAAAAAAA, 32'h0A0B0C0D, 32'h12345678, 32'hC0A80001, 32'h0A000000};
    logic [31:0] mask_pool[4] = '{32'h00000000, 32'hFF000000, 32'hFFFF0000, 32'hFFFFFFFF};
    logic [15:0] port_pool[4] = '{16'd80, 16'd81, 16'd443, 16'd0};

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic void model_eval(input logic [31:0] s, input logic [31:0] d, input logic [15:0] p,
                                       output bit send, output bit hit, output logic [2:0] idx);
        send = 1'b0;
        hit  = 1'b0;
        idx  = 3'd0;
        for (int i = 0; i < NR; i++) begin
            if (!hit && mv[i] && ((s & msm[i]) == (msrc[i] & msm[i]))
                && ((d & mdm[i]) == (mdst[i] & mdm[i])) && (many[i] || p == mdp[i])) begin
                hit  = 1'b1;
                idx  = 3'(i);
                send = mact[i];
            end
        end
    endfunction

    function automatic void model_count(input bit send);
        if (send) begin
            if (exp_pass < (1 << CW) - 1) exp_pass++;
        end else begin
            if (exp_drop < (1 << CW) - 1) exp_drop++;
        end
    endfunction

    task automatic write_rule(input int idx, input bit v, input bit a,
                              input logic [31:0] s, input logic [31:0] sm,
                              input logic [31:0] d, input logic [31:0] dm,
                              input logic [15:0] dp, input bit any);
        @(negedge clk);
        rule_wr_en = 1'b1; rule_wr_idx = 3'(idx); rule_wr_valid = v; rule_wr_action = a;
        rule_wr_src_ip = s; rule_wr_src_mask = sm; rule_wr_dst_ip = d; rule_wr_dst_mask = dm;
        rule_wr_dport = dp; rule_wr_dport_any = any;
        @(negedge clk);
        rule_wr_en = 1'b0;
        if (idx < NR) begin
            mv[idx] = v; mact[idx] = a; msrc[idx] = s; msm[idx] = sm;
            mdst[idx] = d; mdm[idx] = dm; mdp[idx] = dp; many[idx] = any;
        end
    endtask

    // Leaves the bench at the negedge of cycle 3, where the decision must be valid.
    task automatic start_hdr(input logic [31:0] s, input logic [31:0] d, input logic [15:0] p);
        @(negedge clk);
        hdr_src_ip = s; hdr_dst_ip = d; hdr_dst_port = p; hdr_src_port = 16'($urandom);
        hdr_rd = 1'b1;
        @(negedge clk);
        hdr_rd = 1'b0;
        check("lat_c1_rd", m_send_rd, 0);
        @(negedge clk);
        check("lat_c2_rd", m_send_rd, 0);
        @(negedge clk);
        check("lat_c3_rd", m_send_rd, 1);
    endtask

    task automatic clear_out();
        hdr_clear = 1'b1;
        @(negedge clk);
        hdr_clear = 1'b0;
        check("cleared_out", {m_send_rd, m_send, m_rule_hit, m_rule_idx}, 0);
    endtask

    task automatic txn(input string nm, input logic [31:0] s, input logic [31:0] d, input logic [15:0] p,
                       input bit es, input bit eh, input logic [2:0] ei);
        start_hdr(s, d, p);
        model_count(es);
        check({nm, "_send"}, m_send, es);
        check({nm, "_hit"}, m_rule_hit, eh);
        check({nm, "_idx"}, m_rule_idx, ei);
        check({nm, "_pass"}, pass_count, exp_pass);
        check({nm, "_drop"}, drop_count, exp_drop);
        $display("[TB] txn %0d %s src=%h dst=%h dport=%0d -> send=%0b hit=%0b idx=%0d pass=%0d drop=%0d",
                 txn_no, nm, s, d, p, m_send, m_rule_hit, m_rule_idx, pass_count, drop_count);
        txn_no++;
        clear_out();
    endtask

    task automatic model_txn(input string nm, input logic [31:0] s, input logic [31:0] d, input logic [15:0] p);
        bit es, eh;
        logic [2:0] ei;
        model_eval(s, d, p, es, eh, ei);
        txn(nm, s, d, p, es, eh, ei);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; hdr_rd = 1'b0; hdr_clear = 1'b0; stat_clear = 1'b0;
        hdr_src_ip = '0; hdr_dst_ip = '0; hdr_src_port = '0; hdr_dst_port = '0;
        rule_wr_en = 1'b0; rule_wr_idx = '0; rule_wr_valid = 1'b0; rule_wr_action = 1'b0;
        rule_wr_src_ip = '0; rule_wr_src_mask = '0; rule_wr_dst_ip = '0; rule_wr_dst_mask = '0;
        rule_wr_dport = '0; rule_wr_dport_any = 1'b0;
        for (int i = 0; i < NR; i++) begin
            mv[i] = 0; mact[i] = 0; many[i] = 0;
            msrc[i] = '0; msm[i] = '0; mdst[i] = '0; mdm[i] = '0; mdp[i] = '0;
        end
        exp_pass = 0; exp_drop = 0;

        vecs[0] = '{32'hAAAAAAAA, 32'h0A0B0C0D, 16'd80,  1'b0, 1'b1, 3'd0};
        vecs[1] = '{32'hAAAAAAAA, 32'h0B000000, 16'd81,  1'b1, 1'b1, 3'd2};
        vecs[2] = '{32'h12345678, 32'h0B000000, 16'd80,  1'b1, 1'b1, 3'd1};
        vecs[3] = '{32'h12345678, 32'h0B000000, 16'd81,  1'b0, 1'b0, 3'd0};
        vecs[4] = '{32'hAAAAAAAB, 32'hC0A80001, 16'd443, 1'b0, 1'b0, 3'd0};
        vecs[5] = '{32'hAAAAAAAA, 32'h0AFFFFFF, 16'd0,   1'b0, 1'b1, 3'd0};

        repeat (3) @(negedge clk);
        check("reset_outputs", {m_send_rd, m_send, m_rule_hit, m_rule_idx}, 0);
        check("reset_counts", {pass_count, drop_count}, 0);
        rst_n = 1'b1;

        // Empty table: every header takes the default (drop).
        txn("empty_table", 32'h01020304, 32'h05060708, 16'd1234, 1'b0, 1'b0, 3'd0);

        // Walk the drop counter up to all-ones and confirm it sticks there.
        for (int k = 0; k < 15; k++) txn("sat_walk", 32'(k), 32'h0, 16'(k), 1'b0, 1'b0, 3'd0);
        check("sat_drop_allones", drop_count, 4'hF);

        // stat_clear landing on the DECIDE cycle beats the increment.
        @(negedge clk); hdr_src_ip = 32'h1; hdr_dst_ip = 32'h2; hdr_dst_port = 16'd3; hdr_rd = 1'b1;
        @(negedge clk); hdr_rd = 1'b0;
        @(negedge clk); stat_clear = 1'b1;
        @(negedge clk); stat_clear = 1'b0;
        exp_pass = 0; exp_drop = 0;
        check("statclr_rd", m_send_rd, 1);
        check("statclr_counts", {pass_count, drop_count}, 0);
        clear_out();

        // Fixed table for the directed vectors; the write to index 7 must be ignored.
        write_rule(0, 1, 0, 32'h0, 32'h0, 32'h0A000000, 32'hFF000000, 16'd0, 1);
        write_rule(1, 1, 1, 32'h0, 32'h0, 32'h0, 32'h0, 16'd80, 0);
        write_rule(2, 1, 1, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h0, 32'h0, 16'd0, 1);
        write_rule(7, 1, 1, 32'h0, 32'h0, 32'h0, 32'h0, 16'd0, 1);
        for (int k = 0; k < 6; k++)
            txn($sformatf("vec%0d", k), vecs[k].src, vecs[k].dst, vecs[k].dport,
                vecs[k].send, vecs[k].hit, vecs[k].idx);

        // Long wait for hdr_clear: outputs hold and a stray hdr_rd is ignored.
        start_hdr(32'h12345678, 32'h0B000000, 16'd80);
        model_count(1'b1);
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                hdr_src_ip = 32'hAAAAAAAA; hdr_dst_ip = 32'h0A0B0C0D; hdr_rd = 1'b1;
            end else begin
                hdr_rd = 1'b0;
            end
            @(negedge clk);
            check("hold_outputs", {m_send_rd, m_send, m_rule_hit, m_rule_idx}, {1'b1, 1'b1, 1'b1, 3'd1});
        end
        check("hold_counts", {pass_count, drop_count}, {4'(exp_pass), 4'(exp_drop)});
        clear_out();
        txn("after_hold", 32'h12345678, 32'h0B000000, 16'd81, 1'b0, 1'b0, 3'd0);

        // hdr_rd together with hdr_clear: the clear acts, the header is dropped.
        start_hdr(32'hAAAAAAAA, 32'h0A0B0C0D, 16'd80);
        model_count(1'b0);
        hdr_src_ip = 32'h12345678; hdr_dst_ip = 32'h0B000000; hdr_dst_port = 16'd80;
        hdr_rd = 1'b1; hdr_clear = 1'b1;
        @(negedge clk);
        hdr_rd = 1'b0; hdr_clear = 1'b0;
        check("both_cleared", {m_send_rd, m_send, m_rule_hit}, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("both_no_new", m_send_rd, 0);
        end
        check("both_counts", {pass_count, drop_count}, {4'(exp_pass), 4'(exp_drop)});

        // A rule write in the MATCH cycle must not affect the lookup in flight.
        @(negedge clk); hdr_src_ip = 32'h55555555; hdr_dst_ip = 32'h0; hdr_dst_port = 16'd1; hdr_rd = 1'b1;
        @(negedge clk); hdr_rd = 1'b0;
        rule_wr_en = 1'b1; rule_wr_idx = 3'd3; rule_wr_valid = 1'b1; rule_wr_action = 1'b1;
        rule_wr_src_ip = 32'h55555555; rule_wr_src_mask = 32'hFFFFFFFF;
        rule_wr_dst_ip = 32'h0; rule_wr_dst_mask = 32'h0; rule_wr_dport = 16'd0; rule_wr_dport_any = 1'b1;
        @(negedge clk); rule_wr_en = 1'b0;
        @(negedge clk);
        model_count(1'b0);
        check("matchwr_send", m_send, 0);
        check("matchwr_hit", m_rule_hit, 0);
        clear_out();
        mv[3] = 1; mact[3] = 1; msrc[3] = 32'h55555555; msm[3] = 32'hFFFFFFFF;
        mdst[3] = 32'h0; mdm[3] = 32'h0; mdp[3] = 16'd0; many[3] = 1;
        txn("matchwr_next", 32'h55555555, 32'h0, 16'd1, 1'b1, 1'b1, 3'd3);

        // Randomized rule writes, counter clears and headers against the model.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 2) == 0)
                write_rule($urandom_range(0, 7), $urandom_range(0, 3) != 0, 1'($urandom),
                           ip_pool[$urandom_range(0, 4)], mask_pool[$urandom_range(0, 3)],
                           ip_pool[$urandom_range(0, 4)], mask_pool[$urandom_range(0, 3)],
                           port_pool[$urandom_range(0, 3)], 1'($urandom));
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk); stat_clear = 1'b1;
                @(negedge clk); stat_clear = 1'b0;
                exp_pass = 0; exp_drop = 0;
            end
            model_txn("rand",
                      ($urandom_range(0, 5) == 5) ? 32'($urandom) : ip_pool[$urandom_range(0, 4)],
                      ($urandom_range(0, 5) == 5) ? 32'($urandom) : ip_pool[$urandom_range(0, 4)],
                      port_pool[$urandom_range(0, 3)]);
        end

        // Reset during MATCH aborts the lookup and empties the table.
        @(negedge clk); hdr_src_ip = 32'hAAAAAAAA; hdr_dst_ip = 32'h0B000000; hdr_dst_port = 16'd81; hdr_rd = 1'b1;
        @(negedge clk); hdr_rd = 1'b0; rst_n = 1'b0;
        #1;
        check("midreset_outputs", {m_send_rd, m_send, m_rule_hit, m_rule_idx}, 0);
        check("midreset_counts", {pass_count, drop_count}, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) mv[i] = 0;
        exp_pass = 0; exp_drop = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midreset_idle", m_send_rd, 0);
        end
        txn("post_reset", 32'hAAAAAAAA, 32'h0B000000, 16'd81, 1'b0, 1'b0, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
